// File: rtl/lbm_streamer.sv
// lbm_streamer: streams one node's nine post-collision distributions to neighbour slots in raster order.
// Optional macro BOUNDARY_SKIP_EN suppresses writes whose destination lies on the lattice border.
module lbm_streamer #(
  parameter int LATTICE_WIDTH = 64,
  parameter int LATTICE_HEIGHT = 64,
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  localparam int XW = $clog2(LATTICE_WIDTH),
  localparam int YW = $clog2(LATTICE_HEIGHT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       f_new_null,
  input  logic [15:0]       f_new_n,
  input  logic [15:0]       f_new_ne,
  input  logic [15:0]       f_new_e,
  input  logic [15:0]       f_new_se,
  input  logic [15:0]       f_new_s,
  input  logic [15:0]       f_new_sw,
  input  logic [15:0]       f_new_w,
  input  logic [15:0]       f_new_nw,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic [3:0]        wr_dir,
  output logic [XW-1:0]     node_x,
  output logic [YW-1:0]     node_y,
  output logic              busy,
  output logic              frame_done
);
  typedef enum logic {IDLE, WRITE} state_t;
  localparam logic [XW-1:0] XMAX = XW'(LATTICE_WIDTH - 1);
  localparam logic [YW-1:0] YMAX = YW'(LATTICE_HEIGHT - 1);
  state_t            state_q;
  logic [3:0]        dir_q;
  logic [XW-1:0]     x_q, dx;
  logic [YW-1:0]     y_q, dy;
  logic [15:0]       f_q [9];
  logic              frame_done_q;
  logic              east, west, north, south, skip, adv, last_x, last_y;
  logic [ADDR_W-1:0] addr;
  always_comb begin
    east   = dir_q inside {4'd2, 4'd3, 4'd4};
    west   = dir_q inside {4'd6, 4'd7, 4'd8};
    north  = dir_q inside {4'd1, 4'd2, 4'd8};
    south  = dir_q inside {4'd4, 4'd5, 4'd6};
    dx     = east ? (x_q == XMAX ? '0 : x_q + XW'(1)) : west ? (x_q == '0 ? XMAX : x_q - XW'(1)) : x_q;
    dy     = north ? (y_q == YMAX ? '0 : y_q + YW'(1)) : south ? (y_q == '0 ? YMAX : y_q - YW'(1)) : y_q;
    addr   = BASE_ADDR + ((ADDR_W'(dy) * ADDR_W'(LATTICE_WIDTH) + ADDR_W'(dx)) * ADDR_W'(9) + ADDR_W'(dir_q)) * ADDR_W'(2);
    last_x = x_q == XMAX;
    last_y = y_q == YMAX;
  end
  assign busy = state_q == WRITE;
`ifdef BOUNDARY_SKIP_EN
  assign skip = busy && (dx == '0 || dx == XMAX || dy == '0 || dy == YMAX);
`else
  assign skip = 1'b0;
`endif
  assign in_ready   = state_q == IDLE;
  assign wr_valid   = busy && !skip;
  assign adv        = (wr_valid && wr_ready) || skip;
  assign wr_addr    = busy ? addr : '0;
  assign wr_data    = busy ? f_q[dir_q] : '0;
  assign wr_dir     = dir_q;
  assign node_x     = x_q;
  assign node_y     = y_q;
  assign frame_done = frame_done_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      dir_q        <= '0;
      x_q          <= '0;
      y_q          <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (state_q == IDLE) begin
        if (in_valid) begin
          f_q[0]  <= f_new_null;
          f_q[1]  <= f_new_n;
          f_q[2]  <= f_new_ne;
          f_q[3]  <= f_new_e;
          f_q[4]  <= f_new_se;
          f_q[5]  <= f_new_s;
          f_q[6]  <= f_new_sw;
          f_q[7]  <= f_new_w;
          f_q[8]  <= f_new_nw;
          dir_q   <= '0;
          state_q <= WRITE;
        end
      end else if (adv) begin
        dir_q <= dir_q == 4'd8 ? '0 : dir_q + 4'd1;
        if (dir_q == 4'd8) begin
          state_q      <= IDLE;
          x_q          <= last_x ? '0 : x_q + XW'(1);
          if (last_x) y_q <= last_y ? '0 : y_q + YW'(1);
          frame_done_q <= last_x && last_y;
        end
      end
    end
  end
endmodule

// File: tb/tb_lbm_streamer.sv
// tb_lbm_streamer: 4x4 lattice bench with write scoreboard, directed vector table and corner sequences.
module tb_lbm_streamer;
  localparam int W = 4;
  localparam int H = 4;
  logic        clk = 0, rst = 1, in_valid = 0, wr_ready = 1;
  logic [15:0] fi [9];
  logic        in_ready, wr_valid, busy, frame_done;
  logic [31:0] wr_addr;
  logic [15:0] wr_data;
  logic [3:0]  wr_dir;
  logic [1:0]  node_x, node_y;
  int          total = 0, bad = 0, mx = 0, my = 0;
  typedef struct {logic [31:0] a; logic [15:0] d; logic [3:0] r;} exp_t;
  typedef struct {logic [31:0] a; logic [15:0] d;} vec_t;
  exp_t        q [$];

  lbm_streamer #(.LATTICE_WIDTH(W), .LATTICE_HEIGHT(H), .ADDR_W(32), .BASE_ADDR(32'd0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .f_new_null(fi[0]), .f_new_n(fi[1]), .f_new_ne(fi[2]), .f_new_e(fi[3]), .f_new_se(fi[4]),
    .f_new_s(fi[5]), .f_new_sw(fi[6]), .f_new_w(fi[7]), .f_new_nw(fi[8]),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data), .wr_dir(wr_dir),
    .node_x(node_x), .node_y(node_y), .busy(busy), .frame_done(frame_done));

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", n, a, e);
    end
  endtask

  function automatic void m_dest(input int x, input int y, input int d, output int dx, output int dy);
    int cx, cy;
    cx = (d inside {2, 3, 4}) ? 1 : (d inside {6, 7, 8}) ? -1 : 0;
    cy = (d inside {1, 2, 8}) ? 1 : (d inside {4, 5, 6}) ? -1 : 0;
    dx = (x + cx + W) % W;
    dy = (y + cy + H) % H;
  endfunction

  function automatic logic [31:0] m_addr(input int x, input int y, input int d);
    int dx, dy;
    m_dest(x, y, d, dx, dy);
    return 32'(((dy * W + dx) * 9 + d) * 2);
  endfunction

  function automatic bit m_skip(input int x, input int y, input int d);
    int dx, dy;
    m_dest(x, y, d, dx, dy);
`ifdef BOUNDARY_SKIP_EN
    return dx == 0 || dx == W - 1 || dy == 0 || dy == H - 1;
`else
    return (dx < 0) || (dy < 0);
`endif
  endfunction

  // Observes the cycle just before the coming edge: retire writes, enqueue accepted nodes.
  task automatic sb_step();
    exp_t e;
    if (rst) begin
      q.delete();
      mx = 0;
      my = 0;
    end else begin
      if (wr_valid && wr_ready) begin
        if (q.size() == 0) chk("sb_extra_write", wr_addr, 32'hffffffff);
        else begin
          e = q.pop_front();
          chk("sb_addr", wr_addr, e.a);
          chk("sb_data", 32'(wr_data), 32'(e.d));
          chk("sb_dir", 32'(wr_dir), 32'(e.r));
        end
      end
      if (in_valid && in_ready) begin
        chk("acc_x", 32'(node_x), 32'(mx));
        chk("acc_y", 32'(node_y), 32'(my));
        for (int d = 0; d < 9; d++)
          if (!m_skip(mx, my, d)) q.push_back('{m_addr(mx, my, d), fi[d], 4'(d)});
        mx = (mx + 1) % W;
        if (mx == 0) my = (my + 1) % H;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    sb_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1;
    in_valid = 0;
    wr_ready = 1;
    tick();
    tick();
    rst = 0;
  endtask

  initial begin
    int ta [9] = '{0, 74, 94, 24, 242, 226, 282, 68, 142};
    vec_t tv [9];
    int n, cyc, held, stall, acc, fd, last_c;
    for (int i = 0; i < 9; i++) begin
      fi[i] = 16'((i + 1) << 8);
      tv[i] = '{32'(ta[i]), 16'((i + 1) << 8)};
    end
    do_reset();
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_wr_valid", 32'(wr_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_node_x", 32'(node_x), 0);
    chk("rst_node_y", 32'(node_y), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_dir", 32'(wr_dir), 0);
`ifndef BOUNDARY_SKIP_EN
    in_valid = 1;
    tick();
    in_valid = 0;
    for (int i = 0; i < 9; i++) begin
      chk("t1_valid", 32'(wr_valid), 1);
      chk("t1_addr", wr_addr, tv[i].a);
      chk("t1_data", 32'(wr_data), 32'(tv[i].d));
      chk("t1_dir", 32'(wr_dir), 32'(i));
      chk("t1_in_ready", 32'(in_ready), 0);
      tick();
    end
    chk("t1_in_ready_back", 32'(in_ready), 1);
    chk("t1_node_x", 32'(node_x), 1);
    do_reset();
    in_valid = 1;
    tick();
    for (int i = 0; i < 9; i++) fi[i] = 16'hdead;
    cyc = 1;
    held = 0;
    stall = 0;
    while (busy && cyc < 40) begin
      wr_ready = !(wr_dir == 4'd2 && stall < 3);
      chk("t2_in_ready", 32'(in_ready), 0);
      if (wr_dir == 4'd2) begin
        chk("t2_hold_addr", wr_addr, 94);
        chk("t2_hold_data", 32'(wr_data), 32'h0300);
        chk("t2_hold_valid", 32'(wr_valid), 1);
        held++;
      end
      if (!wr_ready) stall++;
      if (wr_dir == 4'd8) in_valid = 0;
      tick();
      cyc++;
    end
    wr_ready = 1;
    chk("t2_held_cycles", 32'(held), 4);
    chk("t2_node_cycles", 32'(cyc), 13);
    chk("t2_in_ready_back", 32'(in_ready), 1);
`endif
    do_reset();
    in_valid = 1;
    acc = 0;
    fd = 0;
    last_c = 0;
    for (int c = 0; c < 250 && acc < 17; c++) begin
      chk("rdy_while_busy", 32'(in_ready & busy), 0);
      if (frame_done) begin
        fd++;
        chk("fd_after_node15", 32'(acc), 16);
        chk("fd_in_ready", 32'(in_ready), 1);
      end
      if (in_ready) begin
        chk("seq_node_x", 32'(node_x), 32'(acc % W));
        chk("seq_node_y", 32'(node_y), 32'((acc / W) % H));
        if (acc > 0) chk("accept_gap", 32'(c - last_c), 10);
        last_c = c;
        acc++;
      end
      tick();
    end
    in_valid = 0;
    chk("accept_count", 32'(acc), 17);
    for (int c = 0; c < 20 && busy; c++) begin
      if (frame_done) fd++;
      tick();
    end
    chk("frame_done_pulses", 32'(fd), 1);
    do_reset();
    in_valid = 1;
    n = 0;
    while (!(busy && wr_dir == 4'd4 && node_x == 2'd2 && node_y == 2'd1) && n < 200) begin
      tick();
      n++;
    end
    chk("t4_reached_dir4", 32'(n < 200), 1);
    rst = 1;
    tick();
    chk("t4_wr_valid", 32'(wr_valid), 0);
    chk("t4_busy", 32'(busy), 0);
    chk("t4_node_x", 32'(node_x), 0);
    chk("t4_node_y", 32'(node_y), 0);
    chk("t4_in_ready", 32'(in_ready), 1);
    chk("t4_wr_addr", wr_addr, 0);
    chk("t4_wr_data", 32'(wr_data), 0);
    rst = 0;
    in_valid = 0;
    for (int i = 0; i < 12; i++) begin
      chk("t4_no_write", 32'(wr_valid), 0);
      tick();
    end
`ifdef BOUNDARY_SKIP_EN
    do_reset();
    in_valid = 1;
    n = 0;
    while (!(in_ready && node_x == 2'd1 && node_y == 2'd1) && n < 200) begin
      tick();
      n++;
    end
    chk("t5_reached_node", 32'(n < 200), 1);
    tick();
    in_valid = 0;
    for (int i = 0; i < 9; i++) begin
      chk("t5_valid", 32'(wr_valid), 32'(i < 4));
      chk("t5_dir", 32'(wr_dir), 32'(i));
      if (i == 0) chk("t5_addr0", wr_addr, 90);
      tick();
    end
    chk("t5_done", 32'(in_ready), 1);
`endif
    chk("sb_empty", 32'(q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
